// File: rtl/iterative_tp_intt.sv
// TP-lane inverse NTT: log2(TP) Gentleman-Sande butterfly stages followed by an
// n_inv scaling stage, each BTF_LAT cycles deep; accepts one transform per cycle.
module iterative_tp_intt #(
  parameter int TP      = 32,
  parameter int LOGQ    = 32,
  parameter int BTF_LAT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [LOGQ-1:0]        q_in,
  input  logic [LOGQ-1:0]        n_inv_in,
  input  logic [LOGQ*TP-1:0]     NTT_in,
  input  logic [LOGQ*(TP-1)-1:0] W_in,
  output logic                   out_valid,
  output logic [LOGQ*TP-1:0]     NTT_out,
  output logic                   busy
);
  localparam int S  = $clog2(TP);
  localparam int L  = (S + 1) * BTF_LAT;
  localparam int DW = LOGQ * TP;
  localparam int WW = LOGQ * (TP - 1);
  localparam int QD = S * BTF_LAT;        // last slot still needing q / n_inv
  localparam int WD = (S - 1) * BTF_LAT;  // last slot still needing twiddles

  typedef logic [LOGQ-1:0] word_t;

  function automatic word_t mod_add(input word_t a, input word_t b, input word_t q);
    logic [LOGQ:0] sm;
    sm = {1'b0, a} + {1'b0, b};
    if (sm >= {1'b0, q}) sm = sm - {1'b0, q};
    return sm[LOGQ-1:0];
  endfunction

  function automatic word_t mod_sub(input word_t a, input word_t b, input word_t q);
    logic [LOGQ:0] df;
    df = {1'b0, a} - {1'b0, b};
    if (df[LOGQ]) df = df + {1'b0, q};
    return df[LOGQ-1:0];
  endfunction

  function automatic word_t mod_mul(input word_t a, input word_t b, input word_t q);
    logic [2*LOGQ-1:0] p;
    p = {{LOGQ{1'b0}}, a} * {{LOGQ{1'b0}}, b};
    return word_t'(p % {{LOGQ{1'b0}}, q});
  endfunction

  function automatic logic [DW-1:0] btf(input logic [DW-1:0] x, input logic [WW-1:0] w,
                                        input word_t q, input int unsigned s);
    logic [DW-1:0] y;
    int unsigned   h, a, b, wi;
    word_t         xa, xb;
    y = x;
    h = 1 << s;
    for (int unsigned p = 0; p < TP / 2; p++) begin
      // butterfly p: insert a zero at bit s to get the top lane, p>>s is the group
      a  = ((p >> s) << (s + 1)) | (p & (h - 1));
      b  = a + h;
      wi = TP - (TP >> s) + (p >> s);
      xa = x[a*LOGQ +: LOGQ];
      xb = x[b*LOGQ +: LOGQ];
      y[a*LOGQ +: LOGQ] = mod_add(xa, xb, q);
      y[b*LOGQ +: LOGQ] = mod_mul(mod_sub(xa, xb, q), w[wi*LOGQ +: LOGQ], q);
    end
    return y;
  endfunction

  function automatic logic [DW-1:0] scale(input logic [DW-1:0] x, input word_t ni,
                                          input word_t q);
    logic [DW-1:0] y;
    y = x;
    for (int unsigned k = 0; k < TP; k++) begin
      y[k*LOGQ +: LOGQ] = mod_mul(x[k*LOGQ +: LOGQ], ni, q);
    end
    return y;
  endfunction

  logic [L-1:0]  v_q;
  logic [DW-1:0] d_q   [L];
  word_t         qm_q  [QD+1];
  word_t         ni_q  [QD+1];
  logic [WW-1:0] w_q   [WD+1];
  logic [DW-1:0] stg_d [S+1];

  for (genvar st = 0; st < S; st++) begin : g_btf
    assign stg_d[st] = btf(d_q[st*BTF_LAT], w_q[st*BTF_LAT], qm_q[st*BTF_LAT], st);
  end
  assign stg_d[S] = scale(d_q[S*BTF_LAT], ni_q[S*BTF_LAT], qm_q[S*BTF_LAT]);

  // Slot st*BTF_LAT holds a stage's operands, slot st*BTF_LAT+1 its result; the
  // remaining slots are delay padding. The final slot doubles as the output hold register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q <= '0;
      for (int unsigned i = 0; i < L; i++) d_q[i] <= '0;
      for (int unsigned i = 0; i <= QD; i++) begin
        qm_q[i] <= '0;
        ni_q[i] <= '0;
      end
      for (int unsigned i = 0; i <= WD; i++) w_q[i] <= '0;
    end else begin
      v_q     <= {v_q[L-2:0], in_valid};
      d_q[0]  <= NTT_in;
      qm_q[0] <= q_in;
      ni_q[0] <= n_inv_in;
      w_q[0]  <= W_in;
      for (int unsigned i = 1; i < L; i++) begin
        if (i != L - 1 || v_q[L-2]) begin
          d_q[i] <= (i % BTF_LAT == 1) ? stg_d[i / BTF_LAT] : d_q[i-1];
        end
      end
      for (int unsigned i = 1; i <= QD; i++) begin
        qm_q[i] <= qm_q[i-1];
        ni_q[i] <= ni_q[i-1];
      end
      for (int unsigned i = 1; i <= WD; i++) w_q[i] <= w_q[i-1];
    end
  end

  assign out_valid = v_q[L-1];
  assign NTT_out   = d_q[L-1];
  assign busy      = |v_q;

endmodule

// File: doc/iterative_tp_intt.md
Name: iterative_tp_intt

Overview:
- Inverse counterpart of the TP-lane forward NTT pipeline.
- Takes TP coefficients in bit-reversed order, which is the forward-NTT output order, plus TP-1 twiddles (inverse roots).
- Applies log2(TP) Gentleman-Sande butterfly stages, then a final multiply of every lane by n_inv.
- Produces TP coefficients in natural order.
- Fully pipelined: one transform may be accepted per cycle. It sits after the pointwise-multiply stage of the polynomial multiplier.

Parameters:
- TP, 32: lanes per transform; power of two, >= 2. S = log2(TP) stages.
- LOGQ, 32: coefficient and modulus width.
- BTF_LAT, 8: cycles per butterfly stage and per scaling stage; >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  NTT_in, W_in, q_in and n_inv_in are valid this cycle.
- q_in  in  LOGQ  modulus; q < 2^(LOGQ-1).
- n_inv_in  in  LOGQ  TP^-1 mod q.
- NTT_in  in  LOGQ*TP  lane k at bits [k*LOGQ +: LOGQ]; every lane < q.
- W_in  in  LOGQ*(TP-1)  twiddle word j at bits [j*LOGQ +: LOGQ].
- out_valid  out  1  NTT_out holds a new result.
- NTT_out  out  LOGQ*TP  lane k at bits [k*LOGQ +: LOGQ], natural order.
- busy  out  1  at least one transform is in flight.

Behaviour:
- Reset: on a clk edge with rst=0, every pipeline register, valid bit and output is cleared. out_valid=0, NTT_out=0, busy=0. In-flight transforms are discarded. Operation resumes on the first edge with rst=1.
- Sampling: on a cycle with in_valid=1, NTT_in, W_in, q_in and n_inv_in are captured. q, n_inv and all twiddles travel with the transform through per-stage delay registers. Inputs may change every cycle without corrupting earlier transforms.
- Latency: L = (S+1)*BTF_LAT. out_valid pulses exactly L cycles after the in_valid sample, for one cycle. Back-to-back inputs produce back-to-back outputs. There is no backpressure.
- Stage s (0..S-1), with h = 2^s:
  - Group g = 0..TP/(2h)-1 uses twiddle word index (TP - (TP>>s)) + g. Twiddle words used per stage: TP/2, TP/4, ... 1; TP-1 in total.
  - For each t in 0..h-1: a = g*2h + t, b = a + h.
  - x_a' = (x_a + x_b) mod q.
  - x_b' = ((x_a - x_b) mod q) * w mod q.
- Scaling stage: every lane becomes x_k * n_inv mod q.
- Arithmetic is exact modular reduction:
  - Add: LOGQ+1-bit sum, then a conditional subtract of q.
  - Subtract: add q on borrow.
  - Multiply: full 2*LOGQ-bit product, reduced to [0,q). Any reduction method is allowed, but each stage must be padded or pipelined to exactly BTF_LAT cycles.
- Output hold: NTT_out updates only on cycles where out_valid=1 and holds its previous value otherwise.
- busy: 1 whenever any internal valid bit is set or out_valid=1.
- Simultaneous events: an in_valid sample on the same cycle that another result exits is legal, and the two are independent. rst=0 together with in_valid=1: the input is dropped.
- Out-of-range inputs (lane >= q, or twiddle >= q): output value is unspecified, but out_valid timing is unchanged.

Test Plan:
- TP=4, LOGQ=8, BTF_LAT=2, q=17, all twiddles 1, n_inv=1, NTT_in lanes [1,2,3,4] -> out_valid exactly 6 cycles later, NTT_out lanes [10,15,13,0].
- Same stimulus with n_inv=13 -> NTT_out [11,8,16,0].
- Round trip: random vectors through the TP=32 forward pipeline, then this block with inverse twiddles and n_inv = 32^-1 mod q, for q=0x7FFFE001 (LOGQ=32) -> output equals the original vector on every lane.
- 20 back-to-back in_valid cycles with distinct vectors and alternating q (17, 97) -> 20 consecutive out_valid cycles, each matching its golden model. busy=1 throughout and drops 1 cycle after the last out_valid.
- rst=0 pulsed for one cycle, 3 cycles after an input -> that transform never emerges. out_valid, busy and NTT_out read 0 after the edge. A new input after reset emerges L cycles later.
- Boundary values: lanes all q-1, twiddles q-1, q = 2^(LOGQ-1)-1 -> results match the golden model, with no overflow in the add/subtract paths.
